// File: rtl/cpu_defs_pkg.sv
// Shared decode definitions: opcode/funct constants, ALU, ALU-source and
// register-destination codes, and the packed control bundle.
package cpu_defs_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Native ALU code width inside the bundle; the top widens it to ALUCTRL_W
    localparam int ALU_W = 3;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'd3;

    localparam logic [1:0] ALUSRC_IMM = 2'd0;
    localparam logic [1:0] ALUSRC_PC  = 2'd1;
    localparam logic [1:0] ALUSRC_DB  = 2'd2;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    typedef struct packed {
        logic [1:0]       regDst;
        logic             extMethod;
        logic             regWr;
        logic [1:0]       aluSrc;
        logic             branch;
        logic             jump;
        logic             jumpReg;
        logic             invZero;
        logic             memWr;
        logic             memToReg;
        logic [ALU_W-1:0] aluCntrl;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // rs is a source operand for everything except the absolute jumps
    function automatic logic readsRs(input logic [5:0] op);
        return !(op == OP_J || op == OP_JAL);
    endfunction

    // rt is a source operand only for R-type, compare-branches and stores
    function automatic logic readsRt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/pipelined_instr_decoder_decode_lut.sv
// Combinational opcode/funct lookup: instruction word -> control bundle.
module decode_lut
    import cpu_defs_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unusedFields;

    assign op           = instr[31:26];
    assign funct        = instr[5:0];
    assign unusedFields = ^instr[25:6];

    // Table decode; unsupported encodings leave every control flag at zero
    always_comb begin
        ctrl    = CTRL_NONE;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: begin
                        ctrl.regDst   = REGDST_RD;
                        ctrl.regWr    = 1'b1;
                        ctrl.aluSrc   = ALUSRC_DB;
                        ctrl.aluCntrl = ALU_ADD;
                    end
                    FN_SUB, FN_SUBU: begin
                        ctrl.regDst   = REGDST_RD;
                        ctrl.regWr    = 1'b1;
                        ctrl.aluSrc   = ALUSRC_DB;
                        ctrl.aluCntrl = ALU_SUB;
                    end
                    FN_SLT: begin
                        ctrl.regDst   = REGDST_RD;
                        ctrl.regWr    = 1'b1;
                        ctrl.aluSrc   = ALUSRC_DB;
                        ctrl.aluCntrl = ALU_SLT;
                    end
                    FN_JR: begin
                        ctrl.jumpReg = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl.regDst   = REGDST_RT;
                ctrl.regWr    = 1'b1;
                ctrl.aluSrc   = ALUSRC_IMM;
                ctrl.aluCntrl = ALU_ADD;
            end
            OP_SLTI: begin
                ctrl.regDst   = REGDST_RT;
                ctrl.regWr    = 1'b1;
                ctrl.aluSrc   = ALUSRC_IMM;
                ctrl.aluCntrl = ALU_SLT;
            end
            OP_BEQ: begin
                ctrl.branch   = 1'b1;
                ctrl.aluSrc   = ALUSRC_IMM;
                ctrl.aluCntrl = ALU_SUB;
            end
            OP_BNE: begin
                ctrl.branch   = 1'b1;
                ctrl.invZero  = 1'b1;
                ctrl.aluSrc   = ALUSRC_IMM;
                ctrl.aluCntrl = ALU_SUB;
            end
            OP_LW: begin
                ctrl.regDst   = REGDST_RT;
                ctrl.regWr    = 1'b1;
                ctrl.memToReg = 1'b1;
                ctrl.aluSrc   = ALUSRC_IMM;
                ctrl.aluCntrl = ALU_ADD;
            end
            OP_SW: begin
                ctrl.memWr    = 1'b1;
                ctrl.aluSrc   = ALUSRC_IMM;
                ctrl.aluCntrl = ALU_ADD;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump     = 1'b1;
                ctrl.regWr    = 1'b1;
                ctrl.regDst   = REGDST_RA;
                ctrl.aluSrc   = ALUSRC_PC;
                ctrl.aluCntrl = ALU_ADD;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_instr_decoder.sv
// Registered MIPS decode stage with valid/ready handshake on both sides,
// load-use interlock and sticky illegal-encoding flag.
module pipelined_instr_decoder
    import cpu_defs_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int ALUCTRL_W    = 3,
    parameter int LOAD_USE_GAP = 1,
    parameter int HAZARD_EN    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            reg_dst,
    output logic                  ext_method,
    output logic                  reg_wr,
    output logic [1:0]            alu_src,
    output logic                  branch,
    output logic                  jump,
    output logic                  jump_reg,
    output logic                  inv_zero,
    output logic                  mem_wr,
    output logic                  mem_to_reg,
    output logic [ALUCTRL_W-1:0]  alu_cntrl,
    output logic [REG_ADDR_W-1:0] rs,
    output logic [REG_ADDR_W-1:0] rt,
    output logic [REG_ADDR_W-1:0] wr_reg,
    output logic [15:0]           imm16,
    output logic [25:0]           jtarget,
    output logic                  illegal,
    output logic                  illegal_seen,
    output logic                  stall
);

    localparam int CNT_W = (LOAD_USE_GAP > 0) ? $clog2(LOAD_USE_GAP + 1) : 1;
    localparam logic [REG_ADDR_W-1:0] RA_REG = REG_ADDR_W'(31);

    logic [5:0]            inOp;
    logic [REG_ADDR_W-1:0] inRs;
    logic [REG_ADDR_W-1:0] inRt;
    logic [REG_ADDR_W-1:0] inRd;
    logic [REG_ADDR_W-1:0] wrRegNext;
    ctrl_t                 decCtrl;
    ctrl_t                 ctrlNext;
    logic                  decIllegal;
    logic                  stallInt;
    logic                  xferIn;

    ctrl_t                 ctrlReg;
    logic                  illegalReg;
    logic                  outValidReg;
    logic                  illegalSeenReg;
    logic [REG_ADDR_W-1:0] rsReg;
    logic [REG_ADDR_W-1:0] rtReg;
    logic [REG_ADDR_W-1:0] wrRegReg;
    logic [15:0]           imm16Reg;
    logic [25:0]           jtargetReg;

    assign inOp = in_instr[31:26];
    assign inRs = REG_ADDR_W'(in_instr[25:21]);
    assign inRt = REG_ADDR_W'(in_instr[20:16]);
    assign inRd = REG_ADDR_W'(in_instr[15:11]);

    decode_lut uDecode (
        .instr   (in_instr),
        .ctrl    (decCtrl),
        .illegal (decIllegal)
    );

    // Resolve the destination register and suppress writes to $0
    always_comb begin
        wrRegNext = inRt;
        case (decCtrl.regDst)
            REGDST_RD: wrRegNext = inRd;
            REGDST_RA: wrRegNext = RA_REG;
            default:   wrRegNext = inRt;
        endcase
        ctrlNext       = decCtrl;
        ctrlNext.regWr = decCtrl.regWr & (wrRegNext != '0);
    end

    assign in_ready = (~outValidReg | out_ready) & ~stallInt;
    assign xferIn   = in_valid & in_ready;
    assign stall    = stallInt;

    generate
        if (HAZARD_EN != 0 && LOAD_USE_GAP > 0) begin : g_hazard
            logic [CNT_W-1:0]      stallCntReg;
            logic [REG_ADDR_W-1:0] ldRegReg;
            logic                  rsHit;
            logic                  rtHit;

            assign rsHit    = readsRs(inOp) && (inRs != '0) && (inRs == ldRegReg);
            assign rtHit    = readsRt(inOp) && (inRt != '0) && (inRt == ldRegReg);
            assign stallInt = in_valid && (stallCntReg != '0) && (rsHit || rtHit);

            // Arm the interlock on a lw issue; count down only while downstream drains
            always_ff @(posedge clk) begin
                if (reset) begin
                    stallCntReg <= '0;
                    ldRegReg    <= '0;
                end else if (xferIn && inOp == OP_LW && wrRegNext != '0) begin
                    stallCntReg <= CNT_W'(LOAD_USE_GAP);
                    ldRegReg    <= wrRegNext;
                end else if (out_ready && stallCntReg != '0) begin
                    stallCntReg <= stallCntReg - 1'b1;
                end
            end
        end else begin : g_noHazard
            logic unusedHazardOp;
            assign unusedHazardOp = ^inOp;
            assign stallInt       = 1'b0;
        end
    endgenerate

    // Output register: load on transfer, drop valid once the bundle is consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            outValidReg <= 1'b0;
            ctrlReg     <= CTRL_NONE;
            illegalReg  <= 1'b0;
            rsReg       <= '0;
            rtReg       <= '0;
            wrRegReg    <= '0;
            imm16Reg    <= '0;
            jtargetReg  <= '0;
        end else if (xferIn) begin
            outValidReg <= 1'b1;
            ctrlReg     <= ctrlNext;
            illegalReg  <= decIllegal;
            rsReg       <= inRs;
            rtReg       <= inRt;
            wrRegReg    <= wrRegNext;
            imm16Reg    <= in_instr[15:0];
            jtargetReg  <= in_instr[25:0];
        end else if (out_ready) begin
            outValidReg <= 1'b0;
        end
    end

    // Sticky flag: any illegal bundle issued since reset
    always_ff @(posedge clk) begin
        if (reset) begin
            illegalSeenReg <= 1'b0;
        end else if (xferIn && decIllegal) begin
            illegalSeenReg <= 1'b1;
        end
    end

    assign out_valid    = outValidReg;
    assign reg_dst      = ctrlReg.regDst;
    assign ext_method   = ctrlReg.extMethod;
    assign reg_wr       = ctrlReg.regWr;
    assign alu_src      = ctrlReg.aluSrc;
    assign branch       = ctrlReg.branch;
    assign jump         = ctrlReg.jump;
    assign jump_reg     = ctrlReg.jumpReg;
    assign inv_zero     = ctrlReg.invZero;
    assign mem_wr       = ctrlReg.memWr;
    assign mem_to_reg   = ctrlReg.memToReg;
    assign alu_cntrl    = ALUCTRL_W'(ctrlReg.aluCntrl);
    assign rs           = rsReg;
    assign rt           = rtReg;
    assign wr_reg       = wrRegReg;
    assign imm16        = imm16Reg;
    assign jtarget      = jtargetReg;
    assign illegal      = illegalReg;
    assign illegal_seen = illegalSeenReg;

endmodule

// File: tb/tb_pipelined_instr_decoder.sv
// Self-checking bench for pipelined_instr_decoder: directed scenarios followed
// by randomized traffic, all checked against an instruction-level model.
module tb_pipelined_instr_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  reg_dst;
    logic        ext_method;
    logic        reg_wr;
    logic [1:0]  alu_src;
    logic        branch, jump, jump_reg, inv_zero, mem_wr, mem_to_reg;
    logic [2:0]  alu_cntrl;
    logic [4:0]  rs, rt, wr_reg;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic        illegal, illegal_seen, stall;

    always #5 clk = ~clk;

    pipelined_instr_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .reg_dst      (reg_dst),
        .ext_method   (ext_method),
        .reg_wr       (reg_wr),
        .alu_src      (alu_src),
        .branch       (branch),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .inv_zero     (inv_zero),
        .mem_wr       (mem_wr),
        .mem_to_reg   (mem_to_reg),
        .alu_cntrl    (alu_cntrl),
        .rs           (rs),
        .rt           (rt),
        .wr_reg       (wr_reg),
        .imm16        (imm16),
        .jtarget      (jtarget),
        .illegal      (illegal),
        .illegal_seen (illegal_seen),
        .stall        (stall)
    );

    int checks   = 0;
    int failures = 0;

    // Instruction-level model of the stage
    typedef struct {
        int regDst;
        bit regWr;
        int aluSrc;
        bit branch, jump, jumpReg, invZero, memWr, memToReg;
        int alu;
        bit illegal;
    } exp_t;

    bit          mValid = 1'b0;
    logic [31:0] mInstr = '0;
    int          mCnt   = 0;
    int          mLd    = 0;
    bit          mSeen  = 1'b0;
    logic        lastStall, lastReady;

    // Expected control per mnemonic, written straight from the decode table
    function automatic exp_t expDecode(input logic [31:0] w);
        exp_t e = '{default: 0};
        int op = int'(w[31:26]);
        int fn = int'(w[5:0]);
        if (op == 0 && (fn == 'h20 || fn == 'h21)) begin e.regDst = 1; e.regWr = 1; e.aluSrc = 2; e.alu = 0; end
        else if (op == 0 && (fn == 'h22 || fn == 'h23)) begin e.regDst = 1; e.regWr = 1; e.aluSrc = 2; e.alu = 1; end
        else if (op == 0 && fn == 'h2A) begin e.regDst = 1; e.regWr = 1; e.aluSrc = 2; e.alu = 3; end
        else if (op == 0 && fn == 'h08) e.jumpReg = 1;
        else if (op == 'h08 || op == 'h09) begin e.regWr = 1; e.alu = 0; end
        else if (op == 'h0A) begin e.regWr = 1; e.alu = 3; end
        else if (op == 'h04) begin e.branch = 1; e.alu = 1; end
        else if (op == 'h05) begin e.branch = 1; e.invZero = 1; e.alu = 1; end
        else if (op == 'h23) begin e.regWr = 1; e.memToReg = 1; e.alu = 0; end
        else if (op == 'h2B) e.memWr = 1;
        else if (op == 'h02) e.jump = 1;
        else if (op == 'h03) begin e.jump = 1; e.regWr = 1; e.regDst = 2; e.aluSrc = 1; end
        else e.illegal = 1;
        return e;
    endfunction

    function automatic int expWr(input logic [31:0] w);
        exp_t e = expDecode(w);
        if (e.regDst == 1) return int'(w[15:11]);
        if (e.regDst == 2) return 31;
        return int'(w[20:16]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutputs();
        exp_t e;
        chk("out_valid", out_valid, mValid);
        chk("illegal_seen", illegal_seen, mSeen);
        if (mValid) begin
            e = expDecode(mInstr);
            chk("reg_dst", reg_dst, e.regDst);
            chk("ext_method", ext_method, 0);
            chk("reg_wr", reg_wr, (e.regWr && expWr(mInstr) != 0) ? 1 : 0);
            chk("alu_src", alu_src, e.aluSrc);
            chk("branch", branch, e.branch);
            chk("jump", jump, e.jump);
            chk("jump_reg", jump_reg, e.jumpReg);
            chk("inv_zero", inv_zero, e.invZero);
            chk("mem_wr", mem_wr, e.memWr);
            chk("mem_to_reg", mem_to_reg, e.memToReg);
            chk("alu_cntrl", alu_cntrl, e.alu);
            chk("rs", rs, mInstr[25:21]);
            chk("rt", rt, mInstr[20:16]);
            chk("wr_reg", wr_reg, expWr(mInstr));
            chk("imm16", imm16, mInstr[15:0]);
            chk("jtarget", jtarget, mInstr[25:0]);
            chk("illegal", illegal, e.illegal);
        end
    endtask

    // One clock of stimulus: check combinational handshake, then registered state
    task automatic cycle(input bit v, input logic [31:0] w, input bit ordy, input bit rst);
        bit   rdRs, rdRt, mStall, mReady, xfer;
        int   op, rsN, rtN;
        exp_t e;
        in_valid  = v;
        in_instr  = w;
        out_ready = ordy;
        reset     = rst;
        #1;
        op   = int'(w[31:26]);
        rsN  = int'(w[25:21]);
        rtN  = int'(w[20:16]);
        rdRs = !(op == 'h02 || op == 'h03);
        rdRt = (op == 0 || op == 'h04 || op == 'h05 || op == 'h2B);
        mStall = v && mCnt != 0 &&
                 ((rdRs && rsN != 0 && rsN == mLd) || (rdRt && rtN != 0 && rtN == mLd));
        mReady = (!mValid || ordy) && !mStall;
        xfer   = v && mReady;
        lastStall = stall;
        lastReady = in_ready;
        chk("stall", stall, mStall);
        chk("in_ready", in_ready, mReady);
        @(posedge clk);
        #1;
        if (rst) begin
            mValid = 0; mCnt = 0; mLd = 0; mSeen = 0;
            $display("reset t=%0t", $time);
        end else begin
            if (mCnt != 0 && ordy) mCnt--;
            if (xfer) begin
                mValid = 1;
                mInstr = w;
                e = expDecode(w);
                if (e.illegal) mSeen = 1;
                if (op == 'h23 && rtN != 0) begin mCnt = 1; mLd = rtN; end
                $display("issue t=%0t instr=%08h", $time, w);
            end else if (ordy) begin
                mValid = 0;
            end
        end
        checkOutputs();
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        logic [4:0]  ra, rb, rc;
        int          k;
        logic [5:0]  fnList [6] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h08};
        logic [5:0]  opList [7] = '{6'h08, 6'h09, 6'h0A, 6'h04, 6'h05, 6'h23, 6'h2B};
        ra = 5'($urandom_range(0, 3));
        rb = 5'($urandom_range(0, 3));
        rc = 5'($urandom_range(0, 3));
        k  = $urandom_range(0, 9);
        if (k < 3)      w = {6'h00, ra, rb, rc, 5'd0, fnList[$urandom_range(0, 5)]};
        else if (k < 7) w = {opList[$urandom_range(0, 6)], ra, rb, 16'($urandom)};
        else if (k == 7) w = {6'h23, ra, rb, 16'($urandom)};
        else if (k == 8) w = {($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03, 26'($urandom)};
        else            w = $urandom;
        return w;
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        cycle(0, 32'h0, 0, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_reg_wr", reg_wr, 0);
        chk("rst_wr_reg", wr_reg, 0);
        chk("rst_alu_src", alu_src, 0);
        chk("rst_illegal_seen", illegal_seen, 0);

        // add $3,$1,$2
        cycle(1, 32'h00221820, 1, 0);
        chk("add_reg_dst", reg_dst, 1);
        chk("add_alu_src", alu_src, 2);
        chk("add_alu", alu_cntrl, 0);
        chk("add_reg_wr", reg_wr, 1);
        chk("add_wr_reg", wr_reg, 3);
        chk("add_out_valid", out_valid, 1);

        // lw $2,4($1) followed by dependent add $3,$2,$2
        cycle(1, 32'h8C220004, 1, 0);
        cycle(1, 32'h00421820, 1, 0);
        chk("lu_stall", lastStall, 1);
        chk("lu_in_ready", lastReady, 0);
        chk("lu_bubble", out_valid, 0);
        cycle(1, 32'h00421820, 1, 0);
        chk("lu_after_stall", lastStall, 0);
        chk("lu_add_issue", out_valid, 1);
        chk("lu_add_wr", wr_reg, 3);

        // jal then bne
        cycle(1, 32'h0C000010, 1, 0);
        chk("jal_jump", jump, 1);
        chk("jal_alu_src", alu_src, 1);
        chk("jal_reg_dst", reg_dst, 2);
        chk("jal_wr_reg", wr_reg, 31);
        chk("jal_jtarget", jtarget, 32'h10);
        cycle(1, 32'h14220003, 1, 0);
        chk("bne_branch", branch, 1);
        chk("bne_inv_zero", inv_zero, 1);
        chk("bne_alu", alu_cntrl, 1);

        // illegal word and sticky flag
        cycle(1, 32'hFC000000, 1, 0);
        chk("ill_illegal", illegal, 1);
        chk("ill_reg_wr", reg_wr, 0);
        chk("ill_jump", jump, 0);
        chk("ill_seen", illegal_seen, 1);
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 1, 0);
        chk("ill_seen_sticky", illegal_seen, 1);

        // addi $0 with downstream back-pressure
        cycle(1, 32'h20200005, 1, 0);
        chk("addi0_reg_wr", reg_wr, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 32'h00221820, 0, 0);
            chk("bp_in_ready", lastReady, 0);
            chk("bp_imm16", imm16, 16'h0005);
            chk("bp_out_valid", out_valid, 1);
        end
        cycle(0, 32'h0, 1, 0);

        // reset during a stall
        cycle(1, 32'h8C220004, 1, 0);
        cycle(1, 32'h00421820, 1, 1);
        chk("rs_stall_before", lastStall, 1);
        chk("rs_out_valid", out_valid, 0);
        chk("rs_seen_cleared", illegal_seen, 0);
        cycle(1, 32'h00421820, 1, 0);
        chk("rs_stall", lastStall, 0);
        chk("rs_in_ready", lastReady, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 8, randInstr(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
